avg_window: RTL and testbench

Parametrised multi-channel windowed averager for the ADC feedback path. It accumulates CH_NUM unsigned sample streams over a measurement window. The window is closed either by an external end pulse or automatically after 2^win_log2 samples. It then computes one truncated average per channel with a single shared sequential divider, or a shift in fixed-window mode. Accumulation of the next window continues while the averages are computed.

---
 rtl/avg_window_if.sv | 29 ++
 rtl/avg_window.sv | 207 ++++++++++++++++++++
 tb/tb_avg_window.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/avg_window_if.sv
// Sample-in / average-out bundle for the windowed averager.
// The averager uses the slave view; the sample source and result consumer use master.
interface avg_window_if #(
  parameter int CH_NUM = 2,
  parameter int DATA_W = 12,
  parameter int OUT_W  = 16,
  parameter int CNT_W  = 32
);
  logic                     sample_valid;
  logic [CH_NUM*DATA_W-1:0] sample_data;
  logic                     mode;
  logic [4:0]               win_log2;
  logic                     window_end;
  logic                     avg_valid;
  logic [CH_NUM*OUT_W-1:0]  avg_data;
  logic [CNT_W-1:0]         avg_count;
  logic                     busy;
  logic                     overrun;

  modport master (
    output sample_valid, sample_data, mode, win_log2, window_end,
    input  avg_valid, avg_data, avg_count, busy, overrun
  );

  modport slave (
    input  sample_valid, sample_data, mode, win_log2, window_end,
    output avg_valid, avg_data, avg_count, busy, overrun
  );
endinterface

// File: rtl/avg_window.sv
// Multi-channel windowed averager for the ADC feedback path: accumulates CH_NUM
// sample streams, snapshots on window close and averages with one shared divider.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no computation; waiting for a window close
// S_LOAD  | load numerator of channel ch into the divider, clear remainder
// S_DIV   | restoring divide, one quotient bit per cycle, ACC_W cycles
// S_SHIFT | fixed window: average of channel ch is sum >> win_log2
// S_DONE  | publish averages and count, pulse avg_valid, back to idle
module avg_window #(
  parameter int CH_NUM = 2,
  parameter int DATA_W = 12,
  parameter int OUT_W  = 16,
  parameter int CNT_W  = 32
) (
  input logic         clk_100M,
  input logic         rst,
  avg_window_if.slave bus
);

  localparam int ACC_W = DATA_W + CNT_W;
  localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int BIT_W = $clog2(ACC_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIV,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t state;

  logic [ACC_W-1:0] acc      [CH_NUM];
  logic [ACC_W-1:0] acc_nxt  [CH_NUM];
  logic [ACC_W-1:0] snap_acc [CH_NUM];
  logic [OUT_W-1:0] res      [CH_NUM];

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] win_size;
  logic [CNT_W-1:0] snap_cnt;
  logic             take;
  logic             close;
  logic             mode_w;
  logic [4:0]       log2_w;
  logic [4:0]       log2_in;
  logic [4:0]       snap_log2;

  logic [CH_W-1:0]  ch;
  logic [BIT_W-1:0] bit_cnt;
  logic [ACC_W-1:0] quo;
  logic [ACC_W-1:0] quo_nxt;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] rem_nxt;
  logic [CNT_W:0]   rem_sh;

  logic                    busy_r;
  logic                    avg_valid_r;
  logic [CH_NUM*OUT_W-1:0] avg_data_r;
  logic [CNT_W-1:0]        avg_count_r;
  logic                    overrun_r;

  assign bus.busy      = busy_r;
  assign bus.avg_valid = avg_valid_r;
  assign bus.avg_data  = avg_data_r;
  assign bus.avg_count = avg_count_r;
  assign bus.overrun   = overrun_r;

  function automatic logic [OUT_W-1:0] sat(input logic [ACC_W-1:0] v);
    if ((v >> OUT_W) != '0) return '1;
    return OUT_W'(v);
  endfunction

  // A saturated counter freezes the whole window so sum and count stay consistent.
  always_comb begin
    take    = bus.sample_valid && (cnt != CNT_MAX);
    cnt_nxt = cnt + CNT_W'(take);
    for (int c = 0; c < CH_NUM; c++) begin
      acc_nxt[c] = take ? acc[c] + ACC_W'(bus.sample_data[c*DATA_W +: DATA_W]) : acc[c];
    end
    win_size = CNT_W'(1) << log2_w;
    close    = mode_w ? (cnt_nxt == win_size) : bus.window_end;
    log2_in  = (int'(bus.win_log2) > CNT_W - 1) ? 5'(CNT_W - 1) : bus.win_log2;
  end

  // Remainder never exceeds the divisor after a step, so its MSB is only
  // needed transiently for the trial compare.
  always_comb begin
    rem_sh = {rem, quo[ACC_W-1]};
    if (rem_sh >= {1'b0, snap_cnt}) begin
      rem_nxt = CNT_W'(rem_sh - {1'b0, snap_cnt});
      quo_nxt = {quo[ACC_W-2:0], 1'b1};
    end else begin
      rem_nxt = CNT_W'(rem_sh);
      quo_nxt = {quo[ACC_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      cnt       <= '0;
      mode_w    <= bus.mode;
      log2_w    <= log2_in;
      overrun_r <= 1'b0;
      for (int c = 0; c < CH_NUM; c++) acc[c] <= '0;
    end else begin
      overrun_r <= close && busy_r;
      if (close) begin
        mode_w <= bus.mode;
        log2_w <= log2_in;
      end
      if (close && !busy_r) begin
        cnt <= '0;
        for (int c = 0; c < CH_NUM; c++) acc[c] <= '0;
      end else begin
        // A dropped close merges into the next window; fixed mode keeps its period.
        cnt <= (close && mode_w) ? '0 : cnt_nxt;
        for (int c = 0; c < CH_NUM; c++) acc[c] <= acc_nxt[c];
      end
    end
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state       <= S_IDLE;
      busy_r      <= 1'b0;
      avg_valid_r <= 1'b0;
      avg_data_r  <= '0;
      avg_count_r <= '0;
      snap_cnt    <= '0;
      snap_log2   <= '0;
      ch          <= '0;
      bit_cnt     <= '0;
      quo         <= '0;
      rem         <= '0;
      for (int c = 0; c < CH_NUM; c++) begin
        snap_acc[c] <= '0;
        res[c]      <= '0;
      end
    end else begin
      avg_valid_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (close) begin
            for (int c = 0; c < CH_NUM; c++) snap_acc[c] <= acc_nxt[c];
            snap_cnt  <= cnt_nxt;
            snap_log2 <= log2_w;
            ch        <= '0;
            busy_r    <= 1'b1;
            if (cnt_nxt == '0) begin
              for (int c = 0; c < CH_NUM; c++) res[c] <= '0;
              state <= S_DONE;
            end else if (mode_w) begin
              state <= S_SHIFT;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          quo     <= snap_acc[ch];
          rem     <= '0;
          bit_cnt <= BIT_W'(ACC_W - 1);
          state   <= S_DIV;
        end
        S_DIV: begin
          quo     <= quo_nxt;
          rem     <= rem_nxt;
          bit_cnt <= bit_cnt - BIT_W'(1);
          if (bit_cnt == '0) begin
            res[ch] <= sat(quo_nxt);
            if (ch == CH_W'(CH_NUM - 1)) begin
              state <= S_DONE;
            end else begin
              ch    <= ch + CH_W'(1);
              state <= S_LOAD;
            end
          end
        end
        S_SHIFT: begin
          res[ch] <= sat(snap_acc[ch] >> snap_log2);
          if (ch == CH_W'(CH_NUM - 1)) begin
            state <= S_DONE;
          end else begin
            ch <= ch + CH_W'(1);
          end
        end
        S_DONE: begin
          avg_valid_r <= 1'b1;
          avg_count_r <= snap_cnt;
          for (int c = 0; c < CH_NUM; c++) avg_data_r[c*OUT_W +: OUT_W] <= res[c];
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avg_window.sv
// Bench for avg_window: directed vector table, hand-written corner sequences and
// randomized traffic, all checked every cycle against a window/sum/count model.
module tb_avg_window;
  localparam int CH_NUM = 2;
  localparam int DATA_W = 12;
  localparam int OUT_W  = 16;
  localparam int CNT_W  = 32;
  localparam int ACC_W  = DATA_W + CNT_W;
  localparam int LAT0   = CH_NUM * (ACC_W + 1) + 1;
  localparam int LAT1   = CH_NUM + 1;

  logic clk_100M = 1'b0;
  logic rst = 1'b1;

  avg_window_if #(.CH_NUM(CH_NUM), .DATA_W(DATA_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

  avg_window #(.CH_NUM(CH_NUM), .DATA_W(DATA_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk_100M (clk_100M),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk_100M = ~clk_100M;

  typedef struct {
    int n;
    int base;
    int stp;
    int c1;
    int e0;
    int e1;
    int ecnt;
  } vec_t;

  vec_t tbl[6];

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  longint m_sum[CH_NUM];
  longint m_cnt;
  bit     m_mode;
  int     m_log2;
  int     m_edge = 0;
  bit     p_valid;
  int     p_due;
  longint p_d[CH_NUM];
  longint p_cnt;
  longint h_d[CH_NUM];
  longint h_cnt;

  bit     saw_valid;
  longint cap_d[CH_NUM];
  longint cap_cnt;
  int     cap_edge;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0d want %0d", name, m_edge, act, exp);
    end
  endtask

  function automatic longint sat_out(input longint q);
    return (q > 65535) ? 65535 : q;
  endfunction

  function automatic int clamp_log2(input int l);
    return (l > CNT_W - 1) ? CNT_W - 1 : l;
  endfunction

  task automatic step(input bit v, input int d0, input int d1, input bit we);
    bit busy_pre;
    bit exp_valid;
    bit exp_ovr;
    bit close;
    int lat;
    bus.sample_valid = v;
    bus.sample_data  = {12'(d1), 12'(d0)};
    bus.window_end   = we;
    @(posedge clk_100M);
    m_edge++;
    busy_pre  = p_valid && (m_edge <= p_due);
    exp_valid = p_valid && (m_edge == p_due);
    exp_ovr   = 1'b0;
    if (exp_valid) begin
      h_d     = p_d;
      h_cnt   = p_cnt;
      p_valid = 1'b0;
    end
    if (v) begin
      m_sum[0] += longint'(d0);
      m_sum[1] += longint'(d1);
      m_cnt++;
    end
    close = m_mode ? (m_cnt == (longint'(1) << m_log2)) : we;
    if (close) begin
      if (busy_pre) begin
        exp_ovr = 1'b1;
        if (m_mode) m_cnt = 0;
      end else begin
        p_valid = 1'b1;
        p_cnt   = m_cnt;
        if (m_cnt == 0) begin
          lat = 1;
          p_d = '{default: 0};
        end else if (m_mode) begin
          lat = LAT1;
          for (int c = 0; c < CH_NUM; c++) p_d[c] = sat_out(m_sum[c] >> m_log2);
        end else begin
          lat = LAT0;
          for (int c = 0; c < CH_NUM; c++) p_d[c] = sat_out(m_sum[c] / m_cnt);
        end
        p_due = m_edge + lat;
        m_sum = '{default: 0};
        m_cnt = 0;
      end
      m_mode = bus.mode;
      m_log2 = clamp_log2(int'(bus.win_log2));
    end
    #1;
    saw_valid = bus.avg_valid;
    if (saw_valid) begin
      cap_d[0] = longint'(bus.avg_data[15:0]);
      cap_d[1] = longint'(bus.avg_data[31:16]);
      cap_cnt  = longint'(bus.avg_count);
      cap_edge = m_edge;
    end
    check("avg_valid", bus.avg_valid, exp_valid);
    check("overrun", bus.overrun, exp_ovr);
    check("busy", bus.busy, p_valid && (m_edge < p_due));
    check("avg_data_ch0", bus.avg_data[15:0], h_d[0]);
    check("avg_data_ch1", bus.avg_data[31:16], h_d[1]);
    check("avg_count", bus.avg_count, h_cnt);
  endtask

  task automatic do_reset(input bit md, input int l2);
    bus.mode         = md;
    bus.win_log2     = 5'(l2);
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    bus.window_end   = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk_100M);
    #1;
    check("rst_avg_valid", bus.avg_valid, 0);
    check("rst_avg_data", bus.avg_data, 0);
    check("rst_avg_count", bus.avg_count, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun, 0);
    rst = 1'b0;
    m_sum   = '{default: 0};
    m_cnt   = 0;
    p_valid = 1'b0;
    h_d     = '{default: 0};
    h_cnt   = 0;
    m_mode  = md;
    m_log2  = clamp_log2(l2);
  endtask

  task automatic wait_valid(input int max_steps, input string tag);
    saw_valid = 1'b0;
    for (int i = 0; i < max_steps && !saw_valid; i++) step(1'b0, 0, 0, 1'b0);
    check({tag, "_timeout"}, saw_valid, 1);
  endtask

  task automatic expect_result(input string tag, input int e0, input int e1, input int ecnt,
                               input int close_edge, input int lat);
    check({tag, "_ch0"}, cap_d[0], e0);
    check({tag, "_ch1"}, cap_d[1], e1);
    check({tag, "_count"}, cap_cnt, ecnt);
    check({tag, "_latency"}, cap_edge - close_edge, lat);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ec;
    bit any_v;

    tbl[0] = '{3, 100, 100, 4095, 200, 4095, 3};
    tbl[1] = '{2, 1, 1, 0, 1, 0, 2};
    tbl[2] = '{5, 10, 3, 7, 16, 7, 5};
    tbl[3] = '{1, 4095, 0, 1, 4095, 1, 1};
    tbl[4] = '{7, 0, 1, 100, 3, 100, 7};
    tbl[5] = '{4, 5, 2, 4094, 8, 4094, 4};

    do_reset(1'b0, 0);

    // external-window vectors, closed together with the last sample
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < tbl[t].n; i++)
        step(1'b1, tbl[t].base + i * tbl[t].stp, tbl[t].c1, i == tbl[t].n - 1);
      ec = m_edge;
      wait_valid(200, $sformatf("vec%0d", t));
      expect_result($sformatf("vec%0d", t), tbl[t].e0, tbl[t].e1, tbl[t].ecnt, ec, LAT0);
    end

    // empty window
    step(1'b0, 0, 0, 1'b1);
    ec = m_edge;
    wait_valid(5, "empty");
    expect_result("empty", 0, 0, 0, ec, 1);

    // close while busy merges the dropped window into the next one
    for (int i = 0; i < 4; i++) step(1'b1, 10, 50, i == 3);
    ec = m_edge;
    step(1'b1, 20, 60, 1'b0);
    step(1'b1, 20, 60, 1'b0);
    step(1'b0, 0, 0, 1'b1);
    check("overrun_pulse", bus.overrun, 1);
    wait_valid(200, "ovr_first");
    expect_result("ovr_first", 10, 50, 4, ec, LAT0);
    step(1'b0, 0, 0, 1'b0);
    step(1'b1, 40, 60, 1'b0);
    step(1'b1, 40, 60, 1'b1);
    ec = m_edge;
    wait_valid(200, "ovr_second");
    expect_result("ovr_second", 30, 60, 4, ec, LAT0);

    // reset in the middle of the divide aborts the result
    step(1'b1, 500, 600, 1'b0);
    step(1'b1, 500, 600, 1'b0);
    step(1'b1, 500, 600, 1'b1);
    repeat (21) step(1'b0, 0, 0, 1'b0);
    check("busy_before_abort", bus.busy, 1);
    do_reset(1'b0, 0);
    any_v = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 0, 0, 1'b0);
      any_v |= saw_valid;
    end
    check("no_valid_after_abort", any_v, 0);
    step(1'b1, 9, 3, 1'b0);
    step(1'b1, 11, 4, 1'b1);
    ec = m_edge;
    wait_valid(200, "post_abort");
    expect_result("post_abort", 10, 3, 2, ec, LAT0);

    // fixed window of 16, stray window_end pulses ignored
    do_reset(1'b1, 4);
    for (int i = 0; i < 16; i++) step(1'b1, i, 8, (i == 5) || (i == 9));
    ec = m_edge;
    wait_valid(10, "fixed16");
    expect_result("fixed16", 7, 8, 16, ec, LAT1);

    // randomized traffic; mode/size changes land on a window boundary
    do_reset(1'b0, 0);
    for (int seg = 0; seg < 8; seg++) begin
      for (int i = 0; i < 200 && p_valid; i++) step(1'b0, 0, 0, 1'b0);
      bus.mode     = 1'($urandom_range(0, 1));
      bus.win_log2 = 5'($urandom_range(0, 4));
      if (!m_mode) step(1'b0, 0, 0, 1'b1);
      for (int i = 0; i < 500; i++)
        step($urandom_range(0, 3) != 0, int'($urandom_range(0, 4095)),
             int'($urandom_range(0, 4095)), $urandom_range(0, 39) == 0);
    end
    repeat (200) step(1'b0, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
